slot_engine: RTL

- Parametrised slot-machine core: N reels, configurable symbol alphabet, credit accounting with coin insertion, bet deduction and tiered payout.
- Next generation of the fixed 3-reel slot state machine. Sits between the clock divider, which supplies `tick`, and the seven-segment display driver, which consumes `reels` and `credits`.
- Reels advance every clk while spinning, so final symbols depend on player timing. Reels stop in staggered order, counted in ticks.

---
 rtl/slot_pkg.sv | 29 ++
 rtl/slot_if.sv | 33 +++
 rtl/slot_reel.sv | 36 +++
 rtl/slot_engine.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// ---------------------------------------------------------------------------
// slot_pkg
// Shared types and helpers for the slot-machine core.
//   state_e       : engine FSM states
//   pay_class_e   : classification of a finished spin
//   tick_cnt_width: bits needed for the stop-timing counter
// ---------------------------------------------------------------------------
package slot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        SCORE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PAIR    = 2'd1,
        JACKPOT = 2'd2
    } pay_class_e;

    // The counter must hold the last reel's stop threshold, where it saturates.
    function automatic int tick_cnt_width(int num_reels, int spin_ticks, int stagger_ticks);
        int t_max;
        t_max = spin_ticks + (num_reels - 1) * stagger_ticks;
        return (t_max < 1) ? 1 : $clog2(t_max + 1);
    endfunction

endpackage

// File: rtl/slot_if.sv
// ---------------------------------------------------------------------------
// slot_if
// Player/display side bus of the slot engine.
//   tick, lever, coin         : stimulus into the engine
//   reels, credits, payout    : registered display values
//   busy, win, no_credit      : status flags / pulses
// master = player/display side, slave = engine.
// ---------------------------------------------------------------------------
interface slot_if #(
    parameter int NUM_REELS = 3,
    parameter int SYM_W     = 4,
    parameter int CREDIT_W  = 8
);
    logic                       tick;
    logic                       lever;
    logic                       coin;
    logic [NUM_REELS*SYM_W-1:0] reels;
    logic [CREDIT_W-1:0]        credits;
    logic                       busy;
    logic                       win;
    logic [CREDIT_W-1:0]        payout;
    logic                       no_credit;

    modport master (
        output tick, lever, coin,
        input  reels, credits, busy, win, payout, no_credit
    );

    modport slave (
        input  tick, lever, coin,
        output reels, credits, busy, win, payout, no_credit
    );
endinterface

// File: rtl/slot_reel.sv
// ---------------------------------------------------------------------------
// slot_reel
// One reel: modulo-NUM_SYMS symbol counter that steps when adv_i is high.
//   clk   : system clock
//   reset : asynchronous active-low reset (symbol returns to 0)
//   adv_i : advance enable
//   sym_o : current symbol, 0..NUM_SYMS-1
// ---------------------------------------------------------------------------
module slot_reel #(
    parameter int SYM_W    = 4,
    parameter int NUM_SYMS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv_i,
    output logic [SYM_W-1:0] sym_o
);
    logic [SYM_W-1:0] sym_q, sym_d;

    always_comb begin
        sym_d = sym_q;
        if (adv_i) begin
            sym_d = (sym_q == SYM_W'(NUM_SYMS - 1)) ? '0 : sym_q + SYM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_q <= '0;
        end else begin
            sym_q <= sym_d;
        end
    end

    assign sym_o = sym_q;
endmodule

// File: rtl/slot_engine.sv
// ---------------------------------------------------------------------------
// slot_engine
// Parametrised slot-machine core: N reels, credit accounting, tiered payout.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slot_if slave (tick/lever/coin in; reels/credits/busy/win/
//           payout/no_credit out, all registered)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a lever edge; bet taken on the pull
// SPIN  | reels advance every clk until their tick threshold is reached
// SCORE | one cycle: compare reels, register payout and win
// ---------------------------------------------------------------------------
module slot_engine
    import slot_pkg::*;
#(
    parameter int NUM_REELS     = 3,
    parameter int SYM_W         = 4,
    parameter int NUM_SYMS      = 10,
    parameter int SPIN_TICKS    = 16,
    parameter int STAGGER_TICKS = 4,
    parameter int CREDIT_W      = 8,
    parameter int START_CREDITS = 10,
    parameter int PAIR_PAY      = 2,
    parameter int JACKPOT_PAY   = 20
) (
    input  logic  clk,
    input  logic  reset,
    slot_if.slave bus
);
    localparam int            TW         = tick_cnt_width(NUM_REELS, SPIN_TICKS, STAGGER_TICKS);
    localparam int            CW2        = CREDIT_W + 2;
    localparam logic [TW-1:0] T_LAST     = TW'(SPIN_TICKS + (NUM_REELS - 1) * STAGGER_TICKS);
    localparam logic [CW2-1:0] CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};

    state_e                     state_q, state_d;
    logic [TW-1:0]              tick_cnt_q, tick_cnt_d;
    logic                       lever_q;
    logic [CREDIT_W-1:0]        credits_q, credits_d;
    logic [CREDIT_W-1:0]        payout_q, payout_d;
    logic                       win_q, win_d;
    logic                       nc_q, nc_d;

    logic [NUM_REELS-1:0]       adv;
    logic [SYM_W-1:0]           sym [NUM_REELS];
    logic [NUM_REELS*SYM_W-1:0] reels_flat;

    logic                       pull;
    logic                       bet;
    logic                       all_eq, any_eq;
    pay_class_e                 pay_class;
    logic [CREDIT_W-1:0]        pay_val;
    logic [CREDIT_W-1:0]        pay_add;
    logic [CW2-1:0]             sum;

    // Reel i keeps spinning while tick_cnt is below its own threshold. Every
    // threshold is <= T_LAST, so nothing advances once the counter saturates.
    for (genvar gi = 0; gi < NUM_REELS; gi++) begin : g_reel
        assign adv[gi] = (state_q == SPIN) &&
                         (tick_cnt_q < TW'(SPIN_TICKS + gi * STAGGER_TICKS));

        slot_reel #(
            .SYM_W    (SYM_W),
            .NUM_SYMS (NUM_SYMS)
        ) u_reel (
            .clk   (clk),
            .reset (reset),
            .adv_i (adv[gi]),
            .sym_o (sym[gi])
        );

        assign reels_flat[gi*SYM_W +: SYM_W] = sym[gi];
    end

    assign pull = bus.lever & ~lever_q;

    always_comb begin
        all_eq    = 1'b1;
        any_eq    = 1'b0;
        pay_class = NONE;
        pay_val   = '0;
        for (int i = 1; i < NUM_REELS; i++) begin
            if (sym[i] != sym[0]) all_eq = 1'b0;
        end
        for (int i = 0; i < NUM_REELS; i++) begin
            for (int j = i + 1; j < NUM_REELS; j++) begin
                if (sym[i] == sym[j]) any_eq = 1'b1;
            end
        end
        if (all_eq)      pay_class = JACKPOT;
        else if (any_eq) pay_class = PAIR;
        case (pay_class)
            JACKPOT: pay_val = CREDIT_W'(JACKPOT_PAY);
            PAIR:    pay_val = CREDIT_W'(PAIR_PAY);
            default: pay_val = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        payout_d   = payout_q;
        win_d      = 1'b0;
        nc_d       = 1'b0;
        bet        = 1'b0;
        pay_add    = '0;

        case (state_q)
            IDLE: begin
                if (pull) begin
                    if (credits_q != '0) begin
                        bet        = 1'b1;
                        payout_d   = '0;
                        tick_cnt_d = '0;
                        state_d    = SPIN;
                    end else begin
                        nc_d = 1'b1;
                    end
                end
            end
            SPIN: begin
                if (tick_cnt_q >= T_LAST) begin
                    state_d = SCORE;
                end else if (bus.tick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            SCORE: begin
                payout_d = pay_val;
                pay_add  = pay_val;
                win_d    = (pay_val != '0);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Single credit update per cycle; the two guard bits catch both the
        // underflow (sign bit) and the overflow past the counter width.
        sum = CW2'(credits_q) + CW2'(bus.coin) + CW2'(pay_add) - CW2'(bet);
        if (sum[CW2-1])          credits_d = '0;
        else if (sum > CREDIT_MAX) credits_d = '1;
        else                     credits_d = sum[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            lever_q    <= 1'b1;   // a lever held through reset must not fire
            credits_q  <= CREDIT_W'(START_CREDITS);
            payout_q   <= '0;
            win_q      <= 1'b0;
            nc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            lever_q    <= bus.lever;
            credits_q  <= credits_d;
            payout_q   <= payout_d;
            win_q      <= win_d;
            nc_q       <= nc_d;
        end
    end

    assign bus.reels     = reels_flat;
    assign bus.credits   = credits_q;
    assign bus.payout    = payout_q;
    assign bus.win       = win_q;
    assign bus.no_credit = nc_q;
    assign bus.busy      = (state_q != IDLE);
endmodule
